// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data-type codes, decoder states and the
// byte positions of the packet-header fields inside a lane-aligned 32-bit word.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_RAW8        = 6'h2A;
    localparam logic [5:0] DT_RAW10       = 6'h2B;
    localparam logic [5:0] DT_RAW12       = 6'h2C;
    localparam logic [5:0] DT_RAW14       = 6'h2D;

    localparam int HDR_DI_LSB    = 0;
    localparam int HDR_WC_LO_LSB = 8;
    localparam int HDR_WC_HI_LSB = 16;
    localparam int HDR_ECC_LSB   = 24;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN
    } state_e;

    function automatic logic is_raw_dt(input logic [5:0] dt);
        return (dt == DT_RAW8) || (dt == DT_RAW10) || (dt == DT_RAW12) || (dt == DT_RAW14);
    endfunction

endpackage

// File: rtl/mipi_rx_ecc_calc.sv
// CSI-2 packet-header ECC generator: 6-bit Hamming parity over the 24 bits
// {WC, DI}. Purely combinational.
module mipi_rx_ecc_calc (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);

    // Each mask selects the header bits that feed one parity bit.
    localparam logic [23:0] P0_MASK = 24'hF12CB7;
    localparam logic [23:0] P1_MASK = 24'hF2555B;
    localparam logic [23:0] P2_MASK = 24'h749A6D;
    localparam logic [23:0] P3_MASK = 24'hB8E38E;
    localparam logic [23:0] P4_MASK = 24'hDF03F0;
    localparam logic [23:0] P5_MASK = 24'hEFFC00;

    assign ecc_o[0] = ^(data_i & P0_MASK);
    assign ecc_o[1] = ^(data_i & P1_MASK);
    assign ecc_o[2] = ^(data_i & P2_MASK);
    assign ecc_o[3] = ^(data_i & P3_MASK);
    assign ecc_o[4] = ^(data_i & P4_MASK);
    assign ecc_o[5] = ^(data_i & P5_MASK);

endmodule

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 packet decoder: parses headers, streams RAW long-packet payload with a
// 1-cycle latency and pulses frame start/end. Header ECC check: MIPI_RX_PKT_ECC_CHECK_EN.
module mipi_rx_packet_decoder
    import mipi_csi_pkg::*;
#(
    parameter logic [1:0] VC_FILTER = 2'd0,
    parameter int         WC_WIDTH  = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        output_valid_o,
    output logic [31:0] data_o,
    output logic [2:0]  packet_type_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        ecc_error_o
);

    localparam logic [WC_WIDTH-1:0] WORD_BYTES = WC_WIDTH'(4);

    state_e                state_q, state_d;
    logic [WC_WIDTH-1:0]   remaining_q, remaining_d;
    logic                  gap_seen_q, gap_seen_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           data_q, data_d;
    logic [2:0]            ptype_q, ptype_d;
    logic                  fs_q, fs_d;
    logic                  fe_q, fe_d;
    logic                  ecc_err_q, ecc_err_d;

    logic [7:0]            hdr_di;
    logic [15:0]           hdr_wc;
    logic                  hdr_start;
    logic                  vc_ok;
    logic                  ecc_ok;

    assign hdr_di = data_i[HDR_DI_LSB +: 8];
    assign hdr_wc = {data_i[HDR_WC_HI_LSB +: 8], data_i[HDR_WC_LO_LSB +: 8]};
    assign vc_ok  = (hdr_di[7:6] == VC_FILTER);

    // Only the first valid word after a low cycle can be a header.
    assign hdr_start = (state_q == IDLE) && data_valid_i && gap_seen_q;

`ifdef MIPI_RX_PKT_ECC_CHECK_EN
    logic [5:0] ecc_calc;

    mipi_rx_ecc_calc u_ecc_calc (
        .data_i (data_i[23:0]),
        .ecc_o  (ecc_calc)
    );

    assign ecc_ok = (data_i[HDR_ECC_LSB +: 8] == {2'b00, ecc_calc});
`else
    assign ecc_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ptype_d     = ptype_q;
        gap_seen_d  = ~data_valid_i;
        out_valid_d = 1'b0;
        data_d      = 32'h0;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        ecc_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hdr_start) begin
                    state_d = DRAIN;
                    if (vc_ok) begin
                        if (!ecc_ok) begin
                            ecc_err_d = 1'b1;
                        end else if (is_raw_dt(hdr_di[5:0])) begin
                            ptype_d     = hdr_di[2:0];
                            remaining_d = WC_WIDTH'(hdr_wc);
                            if (hdr_wc != 16'h0) begin
                                state_d = PAYLOAD;
                            end
                        end else if (hdr_di[5:0] == DT_FRAME_START) begin
                            fs_d = 1'b1;
                        end else if (hdr_di[5:0] == DT_FRAME_END) begin
                            fe_d = 1'b1;
                        end
                    end
                end
            end

            PAYLOAD: begin
                if (data_valid_i) begin
                    out_valid_d = 1'b1;
                    data_d      = data_i;
                    // The final word may be partial; it is forwarded unmasked.
                    if (remaining_q <= WORD_BYTES) begin
                        remaining_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        remaining_d = remaining_q - WORD_BYTES;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                if (!data_valid_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            gap_seen_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= 32'h0;
            ptype_q     <= 3'd0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            ecc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_seen_q  <= gap_seen_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ptype_q     <= ptype_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
            ecc_err_q   <= ecc_err_d;
        end
    end

    assign output_valid_o = out_valid_q;
    assign data_o         = data_q;
    assign packet_type_o  = ptype_q;
    assign frame_start_o  = fs_q;
    assign frame_end_o    = fe_q;
    assign ecc_error_o    = ecc_err_q;

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Scoreboard bench for mipi_rx_packet_decoder: a packet-level reference model
// queues expected payload words and frame/ECC events; a monitor pops and compares.
module tb_mipi_rx_packet_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        output_valid;
    logic [31:0] data_out;
    logic [2:0]  ptype;
    logic        frame_start;
    logic        frame_end;
    logic        ecc_error;

    int tests = 0;
    int fails = 0;

    logic [34:0] exp_words[$];   // {packet_type, data}
    logic [5:0]  exp_events[$];  // {packet_type, fs, fe, ecc_err}
    logic [2:0]  model_type = 3'd0;

    logic [34:0] exp_w;
    logic [5:0]  exp_e;
    logic [5:0]  obs_e;

    always #5 clk = ~clk;

    mipi_rx_packet_decoder #(
        .VC_FILTER (2'd0),
        .WC_WIDTH  (16)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .data_valid_i   (data_valid),
        .data_i         (data_in),
        .output_valid_o (output_valid),
        .data_o         (data_out),
        .packet_type_o  (ptype),
        .frame_start_o  (frame_start),
        .frame_end_o    (frame_end),
        .ecc_error_o    (ecc_error)
    );

`ifdef MIPI_RX_PKT_ECC_CHECK_EN
    // Column view of the Hamming code: each header bit contributes a fixed 6-bit syndrome.
    localparam logic [23:0][5:0] ECC_COL = {
        6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
        6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
        6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

    function automatic logic [7:0] ref_ecc(input logic [23:0] d);
        logic [5:0] acc;
        acc = 6'h0;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) acc = acc ^ ECC_COL[i];
        end
        return {2'b00, acc};
    endfunction
`endif

    function automatic bit is_raw(input logic [5:0] dt);
        return (dt >= 6'h2A) && (dt <= 6'h2D);
    endfunction

    // Monitor: every cycle out of reset, compare what the DUT presents with the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            tests++;
            if (output_valid) begin
                if (exp_words.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got type=%0d data=%h, required no output", ptype, data_out);
                end else begin
                    exp_w = exp_words.pop_front();
                    if ({ptype, data_out} !== exp_w) begin
                        fails++;
                        $display("FAIL payload_word: got type=%0d data=%h, required type=%0d data=%h",
                                 ptype, data_out, exp_w[34:32], exp_w[31:0]);
                    end
                end
            end else if (data_out !== 32'h0) begin
                fails++;
                $display("FAIL idle_data_zero: got data=%h, required 00000000", data_out);
            end

            obs_e = {ptype, frame_start, frame_end, ecc_error};
            if (obs_e[2:0] != 3'b000) begin
                tests++;
                if (exp_events.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got fs/fe/ecc=%b type=%0d, required none", obs_e[2:0], ptype);
                end else begin
                    exp_e = exp_events.pop_front();
                    if (obs_e !== exp_e) begin
                        fails++;
                        $display("FAIL event: got fs/fe/ecc=%b type=%0d, required fs/fe/ecc=%b type=%0d",
                                 obs_e[2:0], obs_e[5:3], exp_e[2:0], exp_e[5:3]);
                    end
                end
            end
        end
    end

    // Drives one packet (header + nbody words) then a low gap, and records what the
    // decoder should emit according to the packet rules.
    task automatic send_packet(input logic [7:0] di, input logic [15:0] wc, input int nbody,
                               input bit bad_ecc, input int gap);
        logic [7:0]  ecc;
        logic [31:0] w;
        bit          vc_ok;
        bit          ecc_good;
        bit          raw_ok;
        int          nw;
`ifdef MIPI_RX_PKT_ECC_CHECK_EN
        ecc = ref_ecc({wc, di});
        if (bad_ecc) ecc = ecc ^ (8'h01 << $urandom_range(0, 5));
        ecc_good = !bad_ecc;
`else
        ecc = 8'($urandom);
        ecc_good = 1'b1;
`endif
        vc_ok  = (di[7:6] == 2'd0);
        raw_ok = 1'b0;
        nw     = (int'(wc) + 3) / 4;

        @(negedge clk);
        data_valid = 1'b1;
        data_in    = {ecc, wc[15:8], wc[7:0], di};
        if (vc_ok && !ecc_good) begin
            exp_events.push_back({model_type, 3'b001});
        end else if (vc_ok && is_raw(di[5:0])) begin
            model_type = di[2:0];
            raw_ok     = 1'b1;
        end else if (vc_ok && di[5:0] == 6'h00) begin
            exp_events.push_back({model_type, 3'b100});
        end else if (vc_ok && di[5:0] == 6'h01) begin
            exp_events.push_back({model_type, 3'b010});
        end

        for (int i = 0; i < nbody; i++) begin
            @(negedge clk);
            w       = $urandom;
            data_in = w;
            if (raw_ok && i < nw) exp_words.push_back({model_type, w});
        end

        @(negedge clk);
        data_valid = 1'b0;
        data_in    = $urandom;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        tests++;
        if ({output_valid, data_out, ptype, frame_start, frame_end, ecc_error} !== 39'h0) begin
            fails++;
            $display("FAIL %s: got valid=%b data=%h type=%0d fs=%b fe=%b ecc=%b, required all 0",
                     tag, output_valid, data_out, ptype, frame_start, frame_end, ecc_error);
        end
    endtask

    // Async reset in the middle of a payload; afterwards the still-valid stream must be ignored.
    task automatic reset_mid_packet();
        logic [31:0] w;
        @(negedge clk);
        data_valid = 1'b1;
`ifdef MIPI_RX_PKT_ECC_CHECK_EN
        data_in = {ref_ecc(24'h00282A), 24'h00282A};
`else
        data_in = 32'h0000282A;
`endif
        model_type = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w       = $urandom;
            data_in = w;
            exp_words.push_back({3'd2, w});
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        @(negedge clk);
        data_in = $urandom;
        @(negedge clk);
        #2;
        reset_n    = 1'b1;
        model_type = 3'd0;
        // Header-looking words while valid stays high: no gap, so nothing is decoded.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in = 32'h0008002B;
        end
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int      kind;
        int      nw;
        int      nbody;
        logic [15:0] wc;
        logic [7:0]  di;
        logic [5:0]  dt;
        logic [1:0]  vc;
        bit          bad;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send_packet(8'h2B, 16'h0014, 6, 1'b0, 2);
        send_packet(8'h2C, 16'h0006, 3, 1'b0, 1);
        send_packet(8'h00, 16'h0001, 0, 1'b0, 2);
        send_packet(8'h01, 16'h0001, 0, 1'b0, 2);
        send_packet(8'h6B, 16'h0014, 6, 1'b0, 2);
        send_packet(8'h1E, 16'h0014, 6, 1'b0, 2);
        send_packet(8'h2B, 16'h0014, 2, 1'b0, 1);
        send_packet(8'h2A, 16'h0008, 3, 1'b0, 2);
        send_packet(8'h2D, 16'h0000, 2, 1'b0, 2);
`ifdef MIPI_RX_PKT_ECC_CHECK_EN
        send_packet(8'h2B, 16'h0014, 6, 1'b1, 2);
        send_packet(8'h00, 16'h0002, 0, 1'b1, 2);
        send_packet(8'h2B, 16'h0014, 6, 1'b0, 2);
`endif
        reset_mid_packet();
        send_packet(8'h2C, 16'h000A, 4, 1'b0, 2);

        for (int p = 0; p < 200; p++) begin
            kind = $urandom_range(0, 9);
            vc   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            wc   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(4, 64));
            case (kind)
                0, 1, 2, 3, 4: dt = 6'($urandom_range(6'h2A, 6'h2D));
                5:             dt = 6'h00;
                6:             dt = 6'h01;
                7:             dt = 6'($urandom_range(2, 15));
                default:       dt = 6'($urandom_range(16, 63));
            endcase
            di = {vc, dt};
            nw = (int'(wc) + 3) / 4;
            if (dt < 6'h10) nbody = $urandom_range(0, 2);
            else if ($urandom_range(0, 5) == 0) nbody = $urandom_range(0, nw);
            else nbody = nw + $urandom_range(1, 3);
`ifdef MIPI_RX_PKT_ECC_CHECK_EN
            bad = ($urandom_range(0, 7) == 0);
`else
            bad = 1'b0;
`endif
            send_packet(di, wc, nbody, bad, $urandom_range(1, 3));
        end

        repeat (5) @(negedge clk);
        tests++;
        if (exp_words.size() != 0) begin
            fails++;
            $display("FAIL words_drained: got %0d words never output, required 0", exp_words.size());
        end
        tests++;
        if (exp_events.size() != 0) begin
            fails++;
            $display("FAIL events_drained: got %0d events never seen, required 0", exp_events.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
